// File: rtl/icap_cmd_pkg.sv
// ---------------------------------------------------------------------------
// icap_cmd_pkg
//   Shared definitions for the ICAP multiboot reboot sequencer:
//     - Virtex-5 configuration command words used by the IPROG sequence
//     - number of words in the sequence
//     - sequencer state encoding (also exported on the debug port)
//     - per-byte bit reversal helper for the ICAP data ordering
// ---------------------------------------------------------------------------
package icap_cmd_pkg;

    // Configuration packet words
    localparam logic [31:0] ICAP_DUMMY     = 32'hFFFF_FFFF;
    localparam logic [31:0] ICAP_SYNC      = 32'hAA99_5566;
    localparam logic [31:0] ICAP_NOOP      = 32'h2000_0000;
    localparam logic [31:0] ICAP_WR_WBSTAR = 32'h3002_0001;  // type-1 write, 1 word, WBSTAR
    localparam logic [31:0] ICAP_WR_CMD    = 32'h3000_8001;  // type-1 write, 1 word, CMD
    localparam logic [31:0] ICAP_IPROG     = 32'h0000_000F;

    // Words in the IPROG sequence; the index counter is sized to match
    localparam int          ICAP_WORD_COUNT = 8;
    localparam logic [2:0]  ICAP_LAST_IDX   = 3'(ICAP_WORD_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } icap_state_e;

    // Reverse the bit order inside each byte, leaving byte order untouched.
    function automatic logic [31:0] bitswap_bytes(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*b + j] = w[8*b + 7 - j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_iprog_rom.sv
// ---------------------------------------------------------------------------
// icap_iprog_rom
//   Combinational word table for the eight-word IPROG sequence. Word 4 is the
//   captured WBSTAR (flash boot address); every other word is a constant.
//   When BITSWAP=1 the selected word is bit-reversed within each byte to match
//   the Virtex-5 ICAP data ordering.
//
// Ports
//   idx        in  3   word index 0..7
//   boot_addr  in  32  captured WBSTAR value
//   word       out 32  word to drive on the ICAP data bus
// ---------------------------------------------------------------------------
module icap_iprog_rom
    import icap_cmd_pkg::*;
#(
    parameter bit BITSWAP = 1'b1
) (
    input  logic [2:0]  idx,
    input  logic [31:0] boot_addr,
    output logic [31:0] word
);

    logic [31:0] raw_word;

    always_comb begin
        raw_word = ICAP_DUMMY;
        case (idx)
            3'd0:    raw_word = ICAP_DUMMY;
            3'd1:    raw_word = ICAP_SYNC;
            3'd2:    raw_word = ICAP_NOOP;
            3'd3:    raw_word = ICAP_WR_WBSTAR;
            3'd4:    raw_word = boot_addr;
            3'd5:    raw_word = ICAP_WR_CMD;
            3'd6:    raw_word = ICAP_IPROG;
            default: raw_word = ICAP_NOOP;
        endcase
    end

    always_comb begin
        word = raw_word;
        if (BITSWAP) begin
            word = bitswap_bytes(raw_word);
        end
    end

endmodule

// File: rtl/icap_reboot_seq.sv
// ---------------------------------------------------------------------------
// icap_reboot_seq
//   Wishbone master that writes the fixed eight-word IPROG sequence into the
//   Virtex-5 ICAP Wishbone slave, triggering a multiboot reconfiguration from
//   a caller-supplied flash address. Sole master on the ICAP port.
//
// Parameters
//   BITSWAP  1 = reverse bits within each byte of every data word
//   TIMEOUT  max strobe cycles per word without ack (legal range 4..255)
//
// Ports
//   clk          in  1   clock
//   reset        in  1   synchronous, active-high
//   go           in  1   start pulse, sampled only while idle
//   boot_addr    in  32  WBSTAR value, captured on the accepted go
//   busy         out 1   sequencer not idle
//   done         out 1   one-cycle pulse on successful completion
//   error        out 1   sticky ack-timeout flag, cleared by the next go
//   icap_cyc_o   out 1   Wishbone cycle
//   icap_stb_o   out 1   Wishbone strobe
//   icap_we_o    out 1   Wishbone write enable
//   icap_dat_o   out 32  Wishbone write data (held while strobes are low)
//   icap_ack_i   in  1   Wishbone acknowledge
//   dbg_state    out 3   current sequencer state
//
// Handshake: a word is transferred on the rising edge where icap_stb_o and
// icap_ack_i are both high. The master holds cyc/stb/we/dat stable from the
// first strobe cycle until that edge, then drops all strobes for at least one
// cycle (GAP) so a slave returning to idle never sees a second request. An
// ack seen outside REQ carries no meaning and is ignored.
// ---------------------------------------------------------------------------
module icap_reboot_seq
    import icap_cmd_pkg::*;
#(
    parameter bit BITSWAP = 1'b1,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [31:0] boot_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        icap_cyc_o,
    output logic        icap_stb_o,
    output logic        icap_we_o,
    output logic [31:0] icap_dat_o,
    input  logic        icap_ack_i,
    output icap_state_e dbg_state
);

    // Counter value on the last permitted strobe cycle of one word.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    icap_state_e state;
    logic [2:0]  idx;
    logic [31:0] addr_q;
    logic [7:0]  tmo_cnt;

    logic [2:0]  rom_idx;
    logic [31:0] rom_word;

    // The data register is loaded on entry to REQ, so the table is looked up
    // for the word about to be sent: word 0 from IDLE, idx+1 from GAP.
    always_comb begin
        rom_idx = 3'd0;
        if (state == ST_GAP) begin
            rom_idx = idx + 3'd1;
        end
    end

    icap_iprog_rom #(
        .BITSWAP (BITSWAP)
    ) u_rom (
        .idx       (rom_idx),
        .boot_addr (addr_q),
        .word      (rom_word)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= 3'd0;
            addr_q     <= 32'd0;
            tmo_cnt    <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            icap_cyc_o <= 1'b0;
            icap_stb_o <= 1'b0;
            icap_we_o  <= 1'b0;
            icap_dat_o <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        addr_q     <= boot_addr;
                        error      <= 1'b0;
                        idx        <= 3'd0;
                        tmo_cnt    <= 8'd0;
                        icap_dat_o <= rom_word;
                        icap_cyc_o <= 1'b1;
                        icap_stb_o <= 1'b1;
                        icap_we_o  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (icap_ack_i) begin
                        icap_cyc_o <= 1'b0;
                        icap_stb_o <= 1'b0;
                        icap_we_o  <= 1'b0;
                        state      <= ST_GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        icap_cyc_o <= 1'b0;
                        icap_stb_o <= 1'b0;
                        icap_we_o  <= 1'b0;
                        state      <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                ST_GAP: begin
                    if (idx == ICAP_LAST_IDX) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx        <= idx + 3'd1;
                        tmo_cnt    <= 8'd0;
                        icap_dat_o <= rom_word;
                        icap_cyc_o <= 1'b1;
                        icap_stb_o <= 1'b1;
                        icap_we_o  <= 1'b1;
                        state      <= ST_REQ;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                ST_ERR: begin
                    // Abort: the remaining words are never sent.
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    icap_cyc_o <= 1'b0;
                    icap_stb_o <= 1'b0;
                    icap_we_o  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icap_reboot_seq.sv
// ---------------------------------------------------------------------------
// tb_icap_reboot_seq
//   Two sequencers run in lockstep from shared go/boot_addr/reset: index 0
//   with BITSWAP=0, index 1 with BITSWAP=1, each with its own ICAP slave
//   model. Cycle n of a run is the period following the edge n-1, where
//   edge 0 is the edge that samples go.
// ---------------------------------------------------------------------------
module tb_icap_reboot_seq;
    import icap_cmd_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n = cyc_n + 1;

    // ---------------- DUT signals ----------------
    logic        go;
    logic [31:0] boot_addr;
    logic [1:0]  busy, done, error, cyc_o, stb, we, ack, slave_ack;
    logic [31:0] dat [2];
    icap_state_e dbg [2];
    logic        stray;

    assign ack = slave_ack | {2{stray}};

    icap_reboot_seq #(.BITSWAP(1'b0), .TIMEOUT(16)) dut0 (
        .clk(clk), .reset(reset), .go(go), .boot_addr(boot_addr),
        .busy(busy[0]), .done(done[0]), .error(error[0]),
        .icap_cyc_o(cyc_o[0]), .icap_stb_o(stb[0]), .icap_we_o(we[0]),
        .icap_dat_o(dat[0]), .icap_ack_i(ack[0]), .dbg_state(dbg[0])
    );

    icap_reboot_seq #(.BITSWAP(1'b1), .TIMEOUT(16)) dut1 (
        .clk(clk), .reset(reset), .go(go), .boot_addr(boot_addr),
        .busy(busy[1]), .done(done[1]), .error(error[1]),
        .icap_cyc_o(cyc_o[1]), .icap_stb_o(stb[1]), .icap_we_o(we[1]),
        .icap_dat_o(dat[1]), .icap_ack_i(ack[1]), .dbg_state(dbg[1])
    );

    // ---------------- slave model + monitor ----------------
    bit          never_ack;
    bit          rand_lat;
    int          lat [2];
    int          scnt [2];
    int          t0;
    int          done_cnt, done_cyc, busy_first, busy_last;
    int          stb_cnt, stb_first, stb_last, err_first;
    int          gap_viol, bus_viol;
    bit          prev_ack;
    logic [31:0] got0_q[$];
    logic [31:0] got1_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin : mon
        int n;
        n = cyc_n - t0 + 1;
        if (done[0]) begin
            done_cnt++;
            done_cyc = n;
        end
        if (busy[0]) begin
            if (busy_first == 0) busy_first = n;
            busy_last = n;
        end
        if (error[0] && err_first == 0) err_first = n;
        if (stb[0]) begin
            stb_cnt++;
            if (stb_first == 0) stb_first = n;
            stb_last = n;
            if (prev_ack) gap_viol++;
        end
        for (int i = 0; i < 2; i++) begin
            if (stb[i]) begin
                if (!(cyc_o[i] && we[i])) bus_viol++;
                scnt[i]++;
                slave_ack[i] = !never_ack && (scnt[i] == lat[i]);
                if (slave_ack[i]) begin
                    if (i == 0) got0_q.push_back(dat[i]);
                    else        got1_q.push_back(dat[i]);
                    lat[i] = rand_lat ? int'($urandom_range(1, 10)) : 3;
                end
            end else begin
                scnt[i]      = 0;
                slave_ack[i] = 1'b0;
            end
        end
        prev_ack = stb[0] && slave_ack[0];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = w[(k & ~7) + 7 - (k % 8)];
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int k, input logic [31:0] a, input bit swp);
        logic [31:0] w;
        case (k)
            0:       w = 32'hFFFF_FFFF;
            1:       w = 32'hAA99_5566;
            2:       w = 32'h2000_0000;
            3:       w = 32'h3002_0001;
            4:       w = a;
            5:       w = 32'h3000_8001;
            6:       w = 32'h0000_000F;
            default: w = 32'h2000_0000;
        endcase
        return swp ? tb_swap(w) : w;
    endfunction

    task automatic check_seq(input string tag, input int d, input logic [31:0] a);
        logic [31:0] got[$];
        logic [31:0] obs;
        if (d == 0) got = got0_q;
        else        got = got1_q;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(exp_word(k, a, d == 1));
        chk($sformatf("%s_d%0d_count", tag, d), 32'(got.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            obs = (k < got.size()) ? got[k] : 32'hxxxx_xxxx;
            chk($sformatf("%s_d%0d_w%0d", tag, d, k), obs, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        done_cnt = 0; done_cyc = 0; busy_first = 0; busy_last = 0;
        stb_cnt = 0; stb_first = 0; stb_last = 0; err_first = 0;
        gap_viol = 0; bus_viol = 0;
        got0_q.delete();
        got1_q.delete();
        for (int i = 0; i < 2; i++) lat[i] = rand_lat ? int'($urandom_range(1, 10)) : 3;
    endtask

    // Returns at the negedge inside cycle 1.
    task automatic start(input logic [31:0] a);
        @(negedge clk);
        clear_stats();
        boot_addr = a;
        go        = 1'b1;
        t0        = cyc_n + 1;
        @(negedge clk);
        go        = 1'b0;
        boot_addr = ~a;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_clean_run(input string tag, input logic [31:0] a);
        check_seq(tag, 0, a);
        check_seq(tag, 1, a);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_gap"}, 32'(gap_viol), 32'd0);
        chk({tag, "_bus"}, 32'(bus_viol), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b1;
        go        = 1'b0;
        boot_addr = 32'd0;
        stray     = 1'b0;
        never_ack = 1'b0;
        rand_lat  = 1'b0;
        slave_ack = 2'b00;
        t0        = 0;
        clear_stats();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ctl", {26'd0, busy[0], done[0], error[0], cyc_o[0], stb[0], we[0]}, 32'd0);
        chk("rst_ctl1", {26'd0, busy[1], done[1], error[1], cyc_o[1], stb[1], we[1]}, 32'd0);
        chk("rst_dat", dat[0], 32'd0);
        chk("rst_state", 32'(dbg[0]), 32'(ST_IDLE));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: nominal run, ack on 3rd strobe cycle
        start(32'h0040_0000);
        repeat (40) @(negedge clk);
        check_clean_run("nom", 32'h0040_0000);
        chk("nom_done_cyc", 32'(done_cyc), 32'd33);
        chk("nom_busy_first", 32'(busy_first), 32'd1);
        chk("nom_busy_last", 32'(busy_last), 32'd33);
        chk("nom_stb_cnt", 32'(stb_cnt), 32'd24);
        chk("swap_dummy", got1_q[0], 32'hFFFF_FFFF);
        chk("swap_sync", got1_q[1], 32'h5599_AA66);
        chk("swap_noop", got1_q[2], 32'h0400_0000);
        chk("swap_wbstar", got1_q[3], 32'h0C40_0080);
        chk("swap_addr", got1_q[4], 32'h0002_0000);
        chk("swap_iprog", got1_q[6], 32'h0000_00F0);

        // 2: slave never acks
        never_ack = 1'b1;
        start(32'h0010_0000);
        repeat (30) @(negedge clk);
        chk("tmo_stb_cnt", 32'(stb_cnt), 32'd16);
        chk("tmo_stb_first", 32'(stb_first), 32'd1);
        chk("tmo_stb_last", 32'(stb_last), 32'd16);
        chk("tmo_err_first", 32'(err_first), 32'd18);
        chk("tmo_busy_last", 32'(busy_last), 32'd17);
        chk("tmo_error", 32'(error), 32'd3);
        chk("tmo_done_cnt", 32'(done_cnt), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_writes", 32'(got0_q.size()), 32'd0);
        never_ack = 1'b0;
        start(32'h0020_0000);
        chk("tmo_err_clear", 32'(error), 32'd0);
        chk("tmo_restart_dat", dat[0], 32'hFFFF_FFFF);
        repeat (39) @(negedge clk);
        check_clean_run("tmo_re", 32'h0020_0000);

        // 3: stray ack in GAP of word 1, go pulsed during REQ of word 3
        start(32'h00A0_0000);
        repeat (7) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (5) @(negedge clk);
        boot_addr = 32'hDEAD_BEEF;
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
        repeat (25) @(negedge clk);
        check_clean_run("busygo", 32'h00A0_0000);
        chk("busygo_done_cyc", 32'(done_cyc), 32'd33);

        // 4: reset during REQ of word 5
        start(32'h0030_0000);
        repeat (21) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {26'd0, busy[0], done[0], error[0], cyc_o[0], stb[0], we[0]}, 32'd0);
        chk("mid_rst_dat", dat[0], 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_writes", 32'(got0_q.size()), 32'd5);
        chk("mid_rst_addr", got0_q[4], 32'h0030_0000);
        chk("mid_rst_done", 32'(done_cnt), 32'd0);
        start(32'h0050_0000);
        repeat (39) @(negedge clk);
        check_clean_run("post_rst", 32'h0050_0000);
        chk("post_rst_done_cyc", 32'(done_cyc), 32'd33);

        // 5: random ack latency 1..10
        rand_lat = 1'b1;
        start(32'h1234_5678);
        wait_idle("rnd0_idle", 200);
        check_clean_run("rnd0", 32'h1234_5678);
        start(32'h00C0_0000);
        wait_idle("rnd1_idle", 200);
        check_clean_run("rnd1", 32'h00C0_0000);
        start(32'h8000_0001);
        wait_idle("rnd2_idle", 200);
        check_clean_run("rnd2", 32'h8000_0001);
        rand_lat = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
